// File: rtl/dbuf_deglitch.sv
// -----------------------------------------------------------------------------
// dbuf_deglitch
//
// Multi-channel digital input buffer for the stepdown control path. Each
// channel synchronises an asynchronous flag into the CELCLK domain, then holds
// back output transitions with a programmable per-channel delay:
//   mode 00  pass        : output follows the synchronised input immediately
//   mode 01  deglitch    : both edges must persist dly+1 sampled cycles
//   mode 10  rise-delay  : only 0->1 edges are delayed
//   mode 11  fall-delay  : only 1->0 edges are delayed
// A one-cycle registered pulse on rise/fall marks every output change.
//
// Ports
//   CELCLK           clock (single domain)
//   CELRST           synchronous, active-high reset
//   CELV/CELG/SUB    supply/ground/substrate, connectivity only
//   i    [NCH]       asynchronous raw inputs
//   mode [2*NCH]     channel k mode at mode[2k+1:2k]
//   dly  [CNT_W*NCH] channel k delay at dly[CNT_W*k +: CNT_W]
//   o    [NCH]       filtered, registered outputs
//   rise [NCH]       one-cycle pulse after o[k] goes 0->1
//   fall [NCH]       one-cycle pulse after o[k] goes 1->0
// -----------------------------------------------------------------------------
module dbuf_deglitch #(
  parameter int             NCH         = 4,
  parameter int             CNT_W       = 6,
  parameter int             SYNC_STAGES = 2,
  parameter logic [NCH-1:0] RESET_VAL   = '0
) (
  input  logic                 CELCLK,
  input  logic                 CELRST,
  input  logic                 CELV,
  input  logic                 CELG,
  input  logic                 SUB,
  input  logic [NCH-1:0]       i,
  input  logic [2*NCH-1:0]     mode,
  input  logic [CNT_W*NCH-1:0] dly,
  output logic [NCH-1:0]       o,
  output logic [NCH-1:0]       rise,
  output logic [NCH-1:0]       fall
);

  // Supply pins exist for netlist connectivity only.
  logic unused_supply;
  assign unused_supply = &{1'b0, CELV, CELG, SUB};

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   o_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   s;
    logic [1:0]             md;
    logic [CNT_W-1:0]       dk;
    logic [CNT_W-1:0]       d;

    assign s  = sync_q[SYNC_STAGES-1];
    assign md = mode[2*k +: 2];
    assign dk = dly[CNT_W*k +: CNT_W];

    // Effective delay for the transition currently pending (s != o). In the
    // asymmetric modes the direction is given by the level s is heading to.
    always_comb begin
      d = '0;
      case (md)
        2'b00:   d = '0;
        2'b01:   d = dk;
        2'b10:   d = s ? dk : '0;
        2'b11:   d = s ? '0 : dk;
        default: d = '0;
      endcase
    end

    // The >= compare lets a lowered dly (or a switch to a faster mode) finish
    // a pending transition on the next edge. cnt stops at d, and d never
    // exceeds 2^CNT_W-1, so the counter cannot wrap.
    always_ff @(posedge CELCLK) begin
      if (CELRST) begin
        sync_q <= {SYNC_STAGES{RESET_VAL[k]}};
        o_q    <= RESET_VAL[k];
        cnt_q  <= '0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], i[k]};
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        if (s == o_q) begin
          // Input is back at (or still at) the output level: a glitch, if
          // any, is discarded and the next excursion counts from zero.
          cnt_q <= '0;
        end else if (cnt_q >= d) begin
          o_q    <= s;
          cnt_q  <= '0;
          rise_q <= s;
          fall_q <= ~s;
        end else begin
          cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end

    assign o[k]    = o_q;
    assign rise[k] = rise_q;
    assign fall[k] = fall_q;
  end

endmodule

// File: tb/tb_dbuf_deglitch.sv
// -----------------------------------------------------------------------------
// tb_dbuf_deglitch
//
// Directed bench for dbuf_deglitch (NCH=4, CNT_W=6, SYNC_STAGES=2,
// RESET_VAL=0). Inputs are driven and outputs sampled on the falling edge.
// "Edge n" below is the n-th rising edge after the inputs were changed,
// counting from 0. A behavioural reference model runs alongside and is
// compared against the DUT every cycle in the mixed-channel phase.
// -----------------------------------------------------------------------------
module tb_dbuf_deglitch;
  localparam int NCH   = 4;
  localparam int CNT_W = 6;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NCH-1:0]       i    = '0;
  logic [2*NCH-1:0]     mode = '0;
  logic [CNT_W*NCH-1:0] dly  = '0;
  logic [NCH-1:0]       o, rise, fall;

  dbuf_deglitch #(
    .NCH(NCH), .CNT_W(CNT_W), .SYNC_STAGES(2), .RESET_VAL('0)
  ) dut (
    .CELCLK(clk), .CELRST(rst), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
    .i(i), .mode(mode), .dly(dly), .o(o), .rise(rise), .fall(fall)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ch(input int k, input logic [1:0] m, input logic [CNT_W-1:0] d);
    mode[2*k +: 2]     = m;
    dly[CNT_W*k +: CNT_W] = d;
  endtask

  // ---------------------------------------------------------------- reference model
  // Tracks the sampled input history and, per channel, how many consecutive
  // edges the sampled level has disagreed with the output.
  logic [1:0]       m_sync [NCH];
  logic [CNT_W-1:0] m_run  [NCH];
  logic [NCH-1:0]   m_o, m_rise, m_fall;

  always @(posedge clk) begin
    logic             s;
    logic [1:0]       md;
    logic [CNT_W-1:0] need;
    for (int k = 0; k < NCH; k++) begin
      if (rst) begin
        m_sync[k] = 2'b00;
        m_run[k]  = '0;
        m_o[k]    = 1'b0;
        m_rise[k] = 1'b0;
        m_fall[k] = 1'b0;
      end else begin
        s  = m_sync[k][1];
        md = mode[2*k +: 2];
        if (md == 2'b01 || (md == 2'b10 && s) || (md == 2'b11 && !s))
          need = dly[CNT_W*k +: CNT_W];
        else
          need = '0;
        m_rise[k] = 1'b0;
        m_fall[k] = 1'b0;
        if (s == m_o[k]) begin
          m_run[k] = '0;
        end else if (m_run[k] < need) begin
          m_run[k] = m_run[k] + 1;
        end else begin
          m_rise[k] = s;
          m_fall[k] = !s;
          m_o[k]    = s;
          m_run[k]  = '0;
        end
        m_sync[k] = {m_sync[k][0], i[k]};
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  int n_hi, n_r, n_f;
  logic seen;

  initial begin
    // Reset held two edges with all inputs high.
    rst = 1'b1;
    i   = '1;
    tick(2);
    check("rst_o", o, 0);
    check("rst_rise", rise, 0);
    check("rst_fall", fall, 0);

    // Pass mode after release: o at edge 2, rise for one cycle.
    rst = 1'b0;
    tick(2);
    check("pass_o_pre", o, 0);
    tick(1);
    check("pass_o", o, 4'hf);
    check("pass_rise", rise, 4'hf);
    check("pass_fall0", fall, 0);
    tick(1);
    check("pass_rise_end", rise, 0);
    i = '0;
    tick(3);
    check("pass_fall_o", o, 0);
    check("pass_fall", fall, 4'hf);
    tick(1);
    check("pass_fall_end", fall, 0);

    // Deglitch ch0, dly=3: held edge lands at edge 5.
    set_ch(0, 2'b01, 6'd3);
    i[0] = 1'b1;
    tick(5);
    check("dg_pre", o, 0);
    tick(1);
    check("dg_o", o, 4'h1);
    check("dg_rise", rise, 4'h1);
    tick(1);
    check("dg_rise_end", rise, 0);
    i[0] = 1'b0;
    tick(5);
    check("dg_fall_pre", o, 4'h1);
    tick(1);
    check("dg_fall_o", o, 0);
    check("dg_fall", fall, 4'h1);
    tick(2);

    // 3-cycle pulse rejected.
    i[0] = 1'b1;
    tick(3);
    i[0] = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick(1);
      if (o[0] || rise[0] || fall[0]) seen = 1'b1;
    end
    check("dg_short_rejected", seen, 0);

    // 4-cycle pulse accepted: o high 4 cycles, one rise, one fall.
    i[0] = 1'b1;
    tick(4);
    i[0] = 1'b0;
    n_hi = 0; n_r = 0; n_f = 0;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      n_hi += int'(o[0]);
      n_r  += int'(rise[0]);
      n_f  += int'(fall[0]);
    end
    check("dg_pulse_width", n_hi, 4);
    check("dg_pulse_rise", n_r, 1);
    check("dg_pulse_fall", n_f, 1);
    set_ch(0, 2'b00, 6'd0);

    // Rise-delay ch1, dly=5: rise at edge 7, fall at edge 2.
    set_ch(1, 2'b10, 6'd5);
    i[1] = 1'b1;
    tick(7);
    check("rd_rise_pre", o, 0);
    tick(1);
    check("rd_rise_o", o, 4'h2);
    check("rd_rise", rise, 4'h2);
    i[1] = 1'b0;
    tick(2);
    check("rd_fall_pre", o, 4'h2);
    tick(1);
    check("rd_fall_o", o, 0);
    check("rd_fall", fall, 4'h2);

    // Fall-delay ch1: mirror image.
    set_ch(1, 2'b11, 6'd5);
    i[1] = 1'b1;
    tick(2);
    check("fd_rise_pre", o, 0);
    tick(1);
    check("fd_rise_o", o, 4'h2);
    check("fd_rise", rise, 4'h2);
    i[1] = 1'b0;
    tick(7);
    check("fd_fall_pre", o, 4'h2);
    tick(1);
    check("fd_fall_o", o, 0);
    check("fd_fall", fall, 4'h2);
    set_ch(1, 2'b00, 6'd0);

    // Mid-count dly rewrite on ch2: cnt=10 after edge 11, dly 20 -> 4.
    set_ch(2, 2'b01, 6'd20);
    i[2] = 1'b1;
    tick(12);
    check("mid_dly_pre", o, 0);
    set_ch(2, 2'b01, 6'd4);
    tick(1);
    check("mid_dly_o", o, 4'h4);
    check("mid_dly_rise", rise, 4'h4);
    // Mode 01 -> 00 mid-count completes on the next edge.
    set_ch(2, 2'b01, 6'd20);
    i[2] = 1'b0;
    tick(7);
    check("mid_mode_pre", o, 4'h4);
    set_ch(2, 2'b00, 6'd20);
    tick(1);
    check("mid_mode_o", o, 0);
    check("mid_mode_fall", fall, 4'h4);
    set_ch(2, 2'b00, 6'd0);

    // Reset at cnt=2 of a dly=6 transition on ch3, then a full restart.
    set_ch(3, 2'b01, 6'd6);
    i[3] = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(1);
    check("rmid_o", o, 0);
    check("rmid_rise", rise, 0);
    rst = 1'b0;
    tick(8);
    check("rmid_restart_pre", o, 0);
    tick(1);
    check("rmid_restart_o", o, 4'h8);
    check("rmid_restart_rise", rise, 4'h8);
    i = '0;
    mode = '0;
    tick(4);

    // Maximum delay on ch0 (63): accepted at edge 65 without wrapping.
    set_ch(0, 2'b01, 6'd63);
    i[0] = 1'b1;
    tick(65);
    check("max_pre", o, 0);
    tick(1);
    check("max_o", o, 4'h1);
    check("max_rise", rise, 4'h1);
    tick(1);

    // Mixed channels against the reference model, random inputs.
    set_ch(0, 2'b10, 6'd63);
    set_ch(1, 2'b01, 6'd2);
    set_ch(2, 2'b11, 6'd3);
    set_ch(3, 2'b00, 6'd0);
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NCH; k++)
        if ($urandom_range(3, 0) == 0) i[k] = ~i[k];
      if (c % 100 == 99) begin
        set_ch(1, 2'($urandom_range(3, 0)), 6'($urandom_range(6, 0)));
        set_ch(3, 2'($urandom_range(3, 0)), 6'($urandom_range(6, 0)));
      end
      tick(1);
      check("model_o", o, m_o);
      check("model_rise", rise, m_rise);
      check("model_fall", fall, m_fall);
    end

    // ---------------------------------------------------------------- report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dbuf_deglitch.md
# dbuf_deglitch

Multi-channel, parametrised successor to the single-bit digital buffer in the stepdown control path. Each channel synchronises an asynchronous digital input into the CELCLK domain and filters it with a programmable per-channel deglitch, rise-only or fall-only delay mode. It also emits one-cycle edge pulses. It sits between analog comparator/flag outputs and the loop-control state machines, replacing chains of plain buffers plus ad-hoc filters.

## Interface
Parameters:
- NCH, 4, number of independent channels
- CNT_W, 6, delay counter width; max programmable delay 2^CNT_W-1 cycles
- SYNC_STAGES, 2, synchroniser depth (legal 2..4)
- RESET_VAL, 0, reset level of every synchroniser flop and every o bit (NCH-bit vector)

Ports:
- CELCLK  in  1  clock (single domain)
- CELRST  in  1  reset; synchronous, active-high
- CELV  in  1  supply, connectivity only, no RTL function
- CELG  in  1  ground, connectivity only, no RTL function
- SUB  in  1  substrate, connectivity only, no RTL function
- i  in  NCH  asynchronous raw inputs
- mode  in  2*NCH  per-channel mode, channel k at mode[2k+1:2k]
- dly  in  CNT_W*NCH  per-channel delay, channel k at dly[CNT_W*k +: CNT_W]
- o  out  NCH  filtered, registered outputs
- rise  out  NCH  one-cycle pulse when o[k] goes 0->1
- fall  out  NCH  one-cycle pulse when o[k] goes 1->0

## Operation
- Per channel: SYNC_STAGES flop chain gives s[k]. Each channel also has a CNT_W-bit counter cnt[k] and a registered o[k].
- Effective delay d for a pending transition (s[k] != o[k]):
  - mode 00 pass: d = 0.
  - mode 01 deglitch: d = dly[k] for both directions.
  - mode 10 rise-delay: d = dly[k] when s=1; d = 0 when s=0.
  - mode 11 fall-delay: d = dly[k] when s=0; d = 0 when s=1.
- Each edge, per channel:
  - If s == o: cnt <= 0.
  - Else if cnt >= d: o <= s, cnt <= 0, and rise/fall pulses per direction.
  - Else: cnt <= cnt+1.
- Compare is >=, so lowering dly mid-count completes the transition on the next edge. The counter never wraps: it cannot exceed 2^CNT_W-1 because d <= that value.
- Glitch rejection: if s returns to o before cnt reaches d, cnt clears and o does not change. A new excursion restarts the count from 0.
- mode and dly are sampled every cycle with no shadowing. A mode change takes effect on the next edge using the current cnt.
- rise and fall are registered. They are high for exactly the cycle following the edge on which o changed. They are mutually exclusive per channel.
- Channels are fully independent: no shared counter and no arbitration.
- CELRST is synchronous. At an edge with CELRST=1, all of the following happen and any pending count is discarded:
  - Sync flops <= RESET_VAL.
  - o <= RESET_VAL.
  - cnt <= 0.
  - rise <= 0, fall <= 0.
- The first edge with CELRST=0 resumes normal sampling.

## Timing
- Reset values: o = RESET_VAL, rise = 0, fall = 0.
- Latency, with edge 0 the first edge sampling the new i level and the level held: o updates at edge SYNC_STAGES + d. rise/fall are high during the cycle after that edge.
- Example, SYNC_STAGES=2, mode 01, dly=3: o changes at edge 5.
- Minimum accepted pulse width in deglitch mode: d+1 consecutive sampled cycles at s. Pulses of d cycles or fewer are rejected.
- An input toggling every cycle in modes 01/10/11 with d>0 never changes o.
- No combinational path from any input to any output.

## Test plan
- Reset: drive CELRST=1 for 2 cycles with i=all 1, RESET_VAL=0 -> o=0, rise=fall=0 during reset. With mode 00, o=1 at edge 2 after release, and rise pulses for one cycle.
- Deglitch: ch0 mode 01, dly=3, i 0->1 held -> o[0] rises at edge 5, rise[0] high one cycle. A 3-cycle pulse (0->1->0) -> o[0] stays 0, no pulse. A 4-cycle pulse -> o[0] high for 4 cycles, one rise and one fall.
- Asymmetric: ch1 mode 10, dly=5 -> rising edge appears at edge 7, falling edge appears at edge 2. Mode 11 with the same dly gives the mirror image.
- Mid-count changes: dly=20, pending transition at cnt=10, dly rewritten to 4 -> o toggles on the next edge. Mode switched 01->00 mid-count -> toggles on the next edge.
- Reset mid-operation: assert CELRST at cnt=2 of a dly=6 transition -> o=RESET_VAL, cnt=0, no pulse. After release, the count restarts from 0.
- Independence: all NCH channels with different modes and dly and random i -> each o[k] matches a per-channel reference model every cycle. dly=2^CNT_W-1 is held without counter wrap.
